// File: rtl/scroll_message_loader_if.sv
// Edit/scroll control and digit-code outputs between the debounced user inputs and the digit mux.
interface scroll_message_loader_if #(
  parameter int MSG_DEPTH = 16,
  parameter int CODE_W    = 4
);
  localparam int LEN_W = $clog2(MSG_DEPTH + 1);

  logic              load_en;
  logic              wr_en;
  logic [CODE_W-1:0] wr_data;
  logic              clear;
  logic [CODE_W-1:0] first;
  logic [CODE_W-1:0] second;
  logic [CODE_W-1:0] third;
  logic [CODE_W-1:0] fourth;
  logic [LEN_W-1:0]  msg_len;
  logic              full;
  logic              wrap_pulse;

  modport master (
    output load_en, wr_en, wr_data, clear,
    input  first, second, third, fourth, msg_len, full, wrap_pulse
  );

  modport slave (
    input  load_en, wr_en, wr_data, clear,
    output first, second, third, fourth, msg_len, full, wrap_pulse
  );
endinterface

// File: rtl/scroll_message_loader.sv
// Message buffer loaded in EDIT mode and scrolled right-to-left across four digits, one frame per edge.
// All digit outputs are registered; the first scroll frame appears on the second edge after load_en falls.
module scroll_message_loader #(
  parameter int                MSG_DEPTH  = 16,
  parameter int                CODE_W     = 4,
  parameter logic [CODE_W-1:0] BLANK_CODE = '0,
  parameter int                GAP        = 1
) (
  input logic                    slow_clock_1Hz,
  input logic                    reset,
  scroll_message_loader_if.slave bus
);
  localparam int LEN_W = $clog2(MSG_DEPTH + 1);
  localparam int POS_W = $clog2(MSG_DEPTH + 3 + GAP + 1);

  typedef enum logic [1:0] {IDLE, EDIT, SCROLL} state_t;

  state_t            state;
  logic [CODE_W-1:0] mem [MSG_DEPTH];
  logic [LEN_W-1:0]  msg_len;
  logic [POS_W-1:0]  pos;
  logic [CODE_W-1:0] digit [4];
  logic              wrap_pulse;
  logic              full;
  logic              append;
  logic              at_pmax;
  logic [CODE_W-1:0] window_code [4];
  logic [CODE_W-1:0] tail_code [4];

  assign full    = (msg_len == LEN_W'(MSG_DEPTH));
  assign append  = (state == SCROLL) ? 1'b0 :
                   ((state == EDIT) && bus.load_en && bus.wr_en && !full && !bus.clear);
  assign at_pmax = (int'(pos) == int'(msg_len) + 2 + GAP);

  // Index math in int so positions before the message start resolve to blank, not to aliased entries.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      window_code[k] = BLANK_CODE;
      tail_code[k]   = BLANK_CODE;
      for (int j = 0; j < MSG_DEPTH; j++) begin
        if (j < int'(msg_len)) begin
          if (j == int'(pos) - k)
            window_code[k] = mem[j];
          if (j == int'(msg_len) - 1 - k)
            tail_code[k] = mem[j];
        end
      end
    end
  end

  always_ff @(posedge slow_clock_1Hz) begin
    for (int j = 0; j < MSG_DEPTH; j++) begin
      if (append && (int'(msg_len) == j))
        mem[j] <= bus.wr_data;
    end
  end

  always_ff @(posedge slow_clock_1Hz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      msg_len    <= '0;
      pos        <= '0;
      wrap_pulse <= 1'b0;
      digit      <= '{default: BLANK_CODE};
    end else if (bus.clear) begin
      state      <= bus.load_en ? EDIT : IDLE;
      msg_len    <= '0;
      pos        <= '0;
      wrap_pulse <= 1'b0;
      digit      <= '{default: BLANK_CODE};
    end else begin
      case (state)
        IDLE: begin
          wrap_pulse <= 1'b0;
          pos        <= '0;
          digit      <= '{default: BLANK_CODE};
          if (bus.load_en)
            state <= EDIT;
        end
        EDIT: begin
          wrap_pulse <= 1'b0;
          if (!bus.load_en) begin
            pos   <= '0;
            digit <= '{default: BLANK_CODE};
            state <= (msg_len != '0) ? SCROLL : IDLE;
          end else if (append) begin
            msg_len  <= msg_len + LEN_W'(1);
            digit[3] <= digit[2];
            digit[2] <= digit[1];
            digit[1] <= digit[0];
            digit[0] <= bus.wr_data;
          end
        end
        SCROLL: begin
          if (bus.load_en) begin
            state      <= EDIT;
            pos        <= '0;
            wrap_pulse <= 1'b0;
            digit      <= tail_code;
          end else begin
            digit <= window_code;
            if (at_pmax) begin
              pos        <= '0;
              wrap_pulse <= 1'b1;
            end else begin
              pos        <= pos + POS_W'(1);
              wrap_pulse <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          wrap_pulse <= 1'b0;
          digit      <= '{default: BLANK_CODE};
        end
      endcase
    end
  end

  assign bus.first      = digit[0];
  assign bus.second     = digit[1];
  assign bus.third      = digit[2];
  assign bus.fourth     = digit[3];
  assign bus.msg_len    = msg_len;
  assign bus.full       = full;
  assign bus.wrap_pulse = wrap_pulse;
endmodule

// File: tb/tb_scroll_message_loader.sv
// Bench for scroll_message_loader: directed vector table, corner sequences and a queue-based random model.
module tb_scroll_message_loader;
  localparam int DEPTH = 16;
  localparam int GAP   = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scroll_message_loader_if #(.MSG_DEPTH(DEPTH), .CODE_W(4)) bus();

  scroll_message_loader #(
    .MSG_DEPTH (DEPTH),
    .CODE_W    (4),
    .BLANK_CODE(4'd0),
    .GAP       (GAP)
  ) dut (
    .slow_clock_1Hz(clk),
    .reset         (reset),
    .bus           (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] actual, input int expected);
    checks++;
    if (actual !== 32'(expected)) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive(input logic le, input logic we, input int wd, input logic clr);
    @(negedge clk);
    bus.load_en = le;
    bus.wr_en   = we;
    bus.wr_data = 4'(wd);
    bus.clear   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int f, input int s, input int t,
                             input int fo, input int len, input int wrap);
    check({tag, ".first"},  32'(bus.first),      f);
    check({tag, ".second"}, 32'(bus.second),     s);
    check({tag, ".third"},  32'(bus.third),      t);
    check({tag, ".fourth"}, 32'(bus.fourth),     fo);
    check({tag, ".len"},    32'(bus.msg_len),    len);
    check({tag, ".full"},   32'(bus.full),       (len == DEPTH) ? 1 : 0);
    check({tag, ".wrap"},   32'(bus.wrap_pulse), wrap);
  endtask

  // Reference model: the message is a queue, the display is derived from it by index arithmetic.
  localparam int M_IDLE = 0, M_EDIT = 1, M_SCROLL = 2;
  int m_mode;
  int m_msg[$];
  int m_pos;
  int m_d[4];
  bit m_wrap;

  function automatic int v(input int i);
    return (i >= 0 && i < m_msg.size()) ? m_msg[i] : 0;
  endfunction

  function automatic void show_blank();
    for (int k = 0; k < 4; k++) m_d[k] = 0;
  endfunction

  function automatic void show_tail();
    for (int k = 0; k < 4; k++) m_d[k] = v(m_msg.size() - 1 - k);
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_msg.delete();
    m_pos  = 0;
    m_wrap = 0;
    show_blank();
  endfunction

  function automatic void model_step(input bit le, input bit we, input int wd, input bit clr);
    if (clr) begin
      m_msg.delete();
      m_pos  = 0;
      m_wrap = 0;
      m_mode = le ? M_EDIT : M_IDLE;
      show_blank();
      return;
    end
    case (m_mode)
      M_IDLE: begin
        m_wrap = 0;
        show_blank();
        if (le) m_mode = M_EDIT;
      end
      M_EDIT: begin
        m_wrap = 0;
        if (!le) begin
          m_pos = 0;
          show_blank();
          m_mode = (m_msg.size() > 0) ? M_SCROLL : M_IDLE;
        end else if (we && m_msg.size() < DEPTH) begin
          m_msg.push_back(wd);
          show_tail();
        end
      end
      default: begin
        if (le) begin
          m_mode = M_EDIT;
          m_pos  = 0;
          m_wrap = 0;
          show_tail();
        end else begin
          for (int k = 0; k < 4; k++) m_d[k] = v(m_pos - k);
          if (m_pos == m_msg.size() + 2 + GAP) begin
            m_pos  = 0;
            m_wrap = 1;
          end else begin
            m_pos++;
            m_wrap = 0;
          end
        end
      end
    endcase
  endfunction

  task automatic do_reset();
    reset       = 1'b1;
    bus.load_en = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 4'd0;
    bus.clear   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit le; bit we; int wd; bit clr;
    int f; int s; int t; int fo; int len; int wrap;
  } vec_t;
  vec_t vt[$];

  task automatic add(input bit le, input bit we, input int wd, input bit clr,
                     input int f, input int s, input int t, input int fo,
                     input int len, input int wrap);
    vt.push_back(vec_t'{le, we, wd, clr, f, s, t, fo, len, wrap});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int first_wrap;
    int wrap_count;
    logic [31:0] act;
    int exp_v;
    bit le;

    // le we wd clr | first second third fourth len wrap
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0,  1, 0, 0, 0, 1, 0);
    add(1, 1, 2, 0,  2, 1, 0, 0, 2, 0);
    add(1, 1, 3, 0,  3, 2, 1, 0, 3, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 3, 0);
    add(0, 0, 0, 0,  1, 0, 0, 0, 3, 0);
    add(0, 0, 0, 0,  2, 1, 0, 0, 3, 0);
    add(0, 0, 0, 0,  3, 2, 1, 0, 3, 0);
    add(0, 0, 0, 0,  0, 3, 2, 1, 3, 0);
    add(0, 0, 0, 0,  0, 0, 3, 2, 3, 0);
    add(0, 0, 0, 0,  0, 0, 0, 3, 3, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 3, 1);
    add(0, 0, 0, 0,  1, 0, 0, 0, 3, 0);
    add(0, 0, 0, 0,  2, 1, 0, 0, 3, 0);
    add(1, 0, 0, 0,  3, 2, 1, 0, 3, 0);
    add(1, 1, 4, 0,  4, 3, 2, 1, 4, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 4, 0);
    add(0, 0, 0, 0,  1, 0, 0, 0, 4, 0);
    add(0, 0, 0, 0,  2, 1, 0, 0, 4, 0);
    add(0, 1, 9, 1,  0, 0, 0, 0, 0, 0);
    add(0, 1, 5, 0,  0, 0, 0, 0, 0, 0);
    add(1, 1, 7, 0,  0, 0, 0, 0, 0, 0);
    add(1, 1, 6, 0,  6, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0,  6, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0,  0, 6, 0, 0, 1, 0);
    add(0, 0, 0, 0,  0, 0, 6, 0, 1, 0);
    add(0, 0, 0, 0,  0, 0, 0, 6, 1, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0,  6, 0, 0, 0, 1, 0);
    add(1, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(0, 1, 3, 0,  0, 0, 0, 0, 0, 0);

    do_reset();
    check_frame("reset", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].le, vt[i].we, vt[i].wd, vt[i].clr);
      check_frame($sformatf("vec%0d", i), vt[i].f, vt[i].s, vt[i].t, vt[i].fo,
                  vt[i].len, vt[i].wrap);
    end

    // Overflow: 16 writes fill the buffer, the 17th is dropped.
    do_reset();
    drive(1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) drive(1, 1, (i * 7 + 3) % 16, 0);
    check_frame("full16", 12, 5, 14, 7, 16, 0);
    drive(1, 1, 9, 0);
    check_frame("write17", 12, 5, 14, 7, 16, 0);

    // Full-length scroll: period is 16+3+GAP = 20 frames.
    drive(0, 0, 0, 0);
    check_frame("full_entry", 0, 0, 0, 0, 16, 0);
    first_wrap = -1;
    wrap_count = 0;
    for (int step = 1; step <= 40; step++) begin
      drive(0, 0, 0, 0);
      if (step == 1) check("full_step1.first", 32'(bus.first), 3);
      if (bus.wrap_pulse === 1'b1) begin
        wrap_count++;
        if (first_wrap < 0) first_wrap = step;
      end
    end
    check("full_scroll.first_wrap", 32'(first_wrap), 20);
    check("full_scroll.wrap_count", 32'(wrap_count), 2);

    // Asynchronous reset between edges mid-scroll.
    do_reset();
    drive(1, 0, 0, 0);
    drive(1, 1, 5, 0);
    drive(1, 1, 6, 0);
    drive(1, 1, 7, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    check_frame("async_pre", 7, 6, 5, 0, 3, 0);
    #2;
    reset = 1'b1;
    #1;
    check_frame("async_now", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      check_frame($sformatf("async_post%0d", i), 0, 0, 0, 0, 0, 0);
    end
    drive(0, 1, 9, 0);
    check_frame("async_idle_wr", 0, 0, 0, 0, 0, 0);

    // Random stimulus against the reference model.
    do_reset();
    le = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit we;
      bit clr;
      int wd;
      if ($urandom_range(0, 11) == 0) le = ~le;
      we  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 59) == 0);
      wd  = int'($urandom_range(0, 15));
      drive(le, we, wd, clr);
      model_step(le, we, wd, clr);
      act   = 32'({bus.first, bus.second, bus.third, bus.fourth,
                   bus.msg_len, bus.full, bus.wrap_pulse});
      exp_v = (m_d[0] << 19) | (m_d[1] << 15) | (m_d[2] << 11) | (m_d[3] << 7) |
              (m_msg.size() << 2) | ((m_msg.size() == DEPTH) ? 2 : 0) | int'(m_wrap);
      check($sformatf("rand%0d.frame", cyc), act, exp_v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
